// File: rtl/apb_bridge_nslv.sv
// rtl/apb_bridge_nslv.sv - APB master bridge with N-slave decoder, response mux, wait timeout
module apb_bridge_nslv #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      transfer,
    input  logic                      read_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   req_idx;
    logic               req_mapped;
    logic               accept;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
    logic               rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_d;
    logic               sel_ready, sel_err;
    logic [DATA_W-1:0]  sel_rdata;

    assign req_idx    = req_addr[SEL_LSB +: IDX_W];
    // Extra bit keeps the compare correct when NUM_SLV is a power of two.
    assign req_mapped = ({1'b0, req_idx} < (IDX_W+1)'(NUM_SLV));
    assign accept     = transfer && req_ready;
    assign PENABLE    = (state == ACCESS);

    // Only the latched slave's handshake signals reach the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        PSEL      = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
                PSEL[i]   = (state == SETUP) || (state == ACCESS);
            end
        end
    end

    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        req_ready   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            SETUP: begin
                state_d    = ACCESS;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (sel_ready) begin
                    req_ready   = 1'b1;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!PWRITE && !sel_err) ? sel_rdata : '0;
                end else if ((TIMEOUT > 0) && (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
                    req_ready   = 1'b1;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            DERR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A request arriving on a completion cycle is decoded directly, skipping IDLE.
        if (accept) begin
            state_d = req_mapped ? SETUP : DERR;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            idx_q     <= '0;
            wait_cnt  <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            if (accept) begin
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
                PWRITE <= ~read_write;
                idx_q  <= req_idx;
            end
        end
    end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// tb/tb_apb_bridge_nslv.sv - randomized bench for apb_bridge_nslv against a transaction-level model
module tb_apb_bridge_nslv;

    localparam int NS_A = 5;
    localparam int NS_B = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO_A = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    logic               transfer, read_write, req_ready, rsp_valid, rsp_err;
    logic [AW-1:0]      req_addr, paddr;
    logic [DW-1:0]      req_wdata, rsp_rdata, pwdata;
    logic [NS_A-1:0]    psel, pready, pslverr;
    logic               penable, pwrite;
    logic [NS_A*DW-1:0] prdata;

    logic               b_transfer, b_read_write, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [AW-1:0]      b_req_addr, b_paddr;
    logic [DW-1:0]      b_req_wdata, b_rsp_rdata, b_pwdata;
    logic [NS_B-1:0]    b_psel, b_pready, b_pslverr;
    logic               b_penable, b_pwrite;
    logic [NS_B*DW-1:0] b_prdata;

    apb_bridge_nslv #(.NUM_SLV(NS_A), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(28), .TIMEOUT(TO_A)) u_dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .read_write(read_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_bridge_nslv #(.NUM_SLV(NS_B), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(28), .TIMEOUT(0)) u_dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(b_transfer), .read_write(b_read_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
    );

    typedef struct {
        int            cyc;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        int            w;
        logic          err;
        logic [DW-1:0] data;
    } txn_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    rsp_t exp_q[$];
    txn_t slv_q[$];
    txn_t cur;
    rsp_t got_e;
    int   acc = 0;
    logic prev_done = 1'b1;
    logic done_now;
    int   prev_rsp = 0;
    logic prev_mapped = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave responder plus protocol and response monitor for DUT A.
    always @(negedge PCLK) begin
        pready  = NS_A'($urandom);
        pslverr = NS_A'($urandom);
        for (int i = 0; i < NS_A; i++) prdata[i*DW +: DW] = $urandom;
        if (PRESET) begin
            prev_done = 1'b1;
        end else begin
            if (psel != '0 && !penable) begin
                if (slv_q.size() > 0) begin
                    cur = slv_q.pop_front();
                    acc = 0;
                end else begin
                    check("setup_without_request", 64'(0), 64'(1));
                end
            end
            for (int i = 0; i < NS_A; i++) begin
                if (psel[i]) begin
                    pready[i]           = penable && (acc >= cur.w);
                    pslverr[i]          = cur.err;
                    prdata[i*DW +: DW]  = cur.data;
                end
            end
            done_now = 1'b0;
            if (psel != '0 && penable) begin
                done_now = (acc >= cur.w);
                acc++;
                if (acc == TO_A) done_now = 1'b1;
            end
            check("psel_onehot", 64'($onehot0(psel)), 64'(1));
            if (penable) check("penable_needs_psel", 64'(|psel), 64'(1));
            if (psel != '0) begin
                check(prev_done ? "setup_penable" : "access_penable", 64'(penable), 64'(!prev_done));
                check("paddr", 64'(paddr), 64'(cur.addr));
                check("pwrite", 64'(pwrite), 64'(cur.wr));
                if (cur.wr) check("pwdata", 64'(pwdata), 64'(cur.wdata));
            end
            prev_done = (psel == '0) || done_now;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    got_e = exp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(got_e.cyc));
                    check("rsp_err", 64'(rsp_err), 64'(got_e.err));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(got_e.rdata));
                end
            end
        end
    end

    // Issue one request; expected response and latency come from the transaction rules.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rd,
                        input int w, input logic se, input logic [DW-1:0] sd, input logic b2b);
        int   g;
        int   lat;
        logic mapped;
        rsp_t e;
        txn_t t;
        transfer   = 1'b1;
        read_write = rd;
        req_addr   = a;
        req_wdata  = wd;
        g = 0;
        while (!req_ready && g < 200) begin
            @(negedge PCLK); #1;
            g++;
        end
        check("accept_bound", 64'(g < 200), 64'(1));
        if (b2b) check("b2b_accept_cycle", 64'(cyc), 64'(prev_mapped ? prev_rsp - 1 : prev_rsp));
        mapped = (int'(a[30:28]) < NS_A);
        if (mapped) begin
            lat     = 2 + ((w < TO_A) ? w + 1 : TO_A);
            e.err   = (w >= TO_A) || se;
            e.rdata = (rd && !e.err) ? sd : '0;
            t.addr = a; t.wdata = wd; t.wr = !rd; t.w = w; t.err = se; t.data = sd;
            slv_q.push_back(t);
        end else begin
            lat     = 2;
            e.err   = 1'b1;
            e.rdata = '0;
        end
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        prev_rsp    = e.cyc;
        prev_mapped = mapped;
        @(negedge PCLK); #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        transfer = 1'b0;
        while (exp_q.size() > 0 && g < 200) begin
            @(negedge PCLK); #1;
            g++;
        end
        check("drain_bound", 64'(exp_q.size()), 64'(0));
        repeat (2) begin @(negedge PCLK); #1; end
    endtask

    initial begin
        int            c0;
        int            idx, w, r;
        logic          b2b;
        logic [AW-1:0] a;
        txn_t          t;
        PRESET = 1'b1;
        transfer = 1'b0; read_write = 1'b0; req_addr = '0; req_wdata = '0;
        b_transfer = 1'b0; b_read_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_pready = '0; b_pslverr = '0; b_prdata = '0;
        repeat (3) @(negedge PCLK);
        #1;
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        PRESET = 1'b0;
        @(negedge PCLK); #1;

        // DUT B: unmapped slave 3 of 3, then an indefinite wait with TIMEOUT=0.
        b_transfer = 1'b1; b_read_write = 1'b1; b_req_addr = 32'h3000_0000;
        check("b_req_ready_idle", 64'(b_req_ready), 64'(1));
        c0 = cyc;
        @(negedge PCLK); #1;
        b_transfer = 1'b0;
        check("b_derr_psel", 64'(b_psel), 64'(0));
        check("b_derr_rsp_early", 64'(b_rsp_valid), 64'(0));
        @(negedge PCLK); #1;
        check("b_derr_latency", 64'(cyc - c0), 64'(2));
        check("b_derr_rsp_valid", 64'(b_rsp_valid), 64'(1));
        check("b_derr_rsp_err", 64'(b_rsp_err), 64'(1));
        check("b_derr_rsp_rdata", 64'(b_rsp_rdata), 64'(0));
        check("b_derr_psel2", 64'(b_psel), 64'(0));
        @(negedge PCLK); #1;
        check("b_derr_rsp_once", 64'(b_rsp_valid), 64'(0));
        b_pready = 3'b110;
        b_prdata = {3{32'h5555_AAAA}};
        b_transfer = 1'b1; b_read_write = 1'b1; b_req_addr = 32'h0000_0040;
        @(negedge PCLK); #1;
        b_transfer = 1'b0;
        repeat (40) begin @(negedge PCLK); #1; end
        check("b_hold_psel", 64'(b_psel), 64'(3'b001));
        check("b_hold_penable", 64'(b_penable), 64'(1));
        check("b_hold_no_rsp", 64'(b_rsp_valid), 64'(0));
        b_pready[0] = 1'b1;
        b_prdata[31:0] = 32'hCAFE_F00D;
        @(negedge PCLK); #1;
        check("b_late_rsp_valid", 64'(b_rsp_valid), 64'(1));
        check("b_late_rsp_err", 64'(b_rsp_err), 64'(0));
        check("b_late_rsp_rdata", 64'(b_rsp_rdata), 64'(32'hCAFE_F00D));
        check("b_late_psel", 64'(b_psel), 64'(0));

        // DUT A directed cases.
        send(32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0BAD_0BAD, 1'b0);
        drain();
        send(32'h2000_0010, 32'h0, 1'b1, 3, 1'b0, 32'h1234_5678, 1'b0);
        drain();
        send(32'h0000_0100, 32'h1111_2222, 1'b0, 1, 1'b0, 32'h0, 1'b0);
        send(32'h3000_0200, 32'h3333_4444, 1'b0, 0, 1'b1, 32'h0, 1'b1);
        drain();
        send(32'h0000_0000, 32'h0, 1'b1, 30, 1'b0, 32'h7777_7777, 1'b0);
        send(32'h4000_0000, 32'h0, 1'b1, 15, 1'b0, 32'h8888_9999, 1'b1);
        send(32'h6000_0000, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b1);
        drain();

        // DUT A randomized traffic.
        for (int n = 0; n < 60; n++) begin
            idx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NS_A - 1) : $urandom_range(NS_A, 7);
            r = $urandom_range(0, 9);
            if (r < 6)       w = $urandom_range(0, 3);
            else if (r == 6) w = TO_A - 1;
            else if (r == 7) w = TO_A;
            else if (r == 8) w = $urandom_range(TO_A + 1, TO_A + 8);
            else             w = 0;
            a = {1'($urandom), 3'(idx), 28'($urandom)};
            b2b = (n > 0) && ($urandom_range(0, 1) == 1);
            if (!b2b) begin
                transfer = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(negedge PCLK); #1; end
            end
            send(a, $urandom, 1'($urandom), w, ($urandom_range(0, 3) == 0), $urandom, b2b);
        end
        drain();

        // Reset in the middle of an ACCESS wait.
        t.addr = 32'h2000_0080; t.wdata = 32'h0; t.wr = 1'b0; t.w = 100; t.err = 1'b0; t.data = 32'h0;
        slv_q.push_back(t);
        transfer = 1'b1; read_write = 1'b1; req_addr = t.addr; req_wdata = 32'h0;
        check("mid_req_ready", 64'(req_ready), 64'(1));
        @(negedge PCLK); #1;
        transfer = 1'b0;
        repeat (5) begin @(negedge PCLK); #1; end
        check("mid_in_access", 64'(penable), 64'(1));
        PRESET = 1'b1;
        @(negedge PCLK); #1;
        PRESET = 1'b0;
        check("mid_rst_psel", 64'(psel), 64'(0));
        check("mid_rst_penable", 64'(penable), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_paddr", 64'(paddr), 64'(0));
        repeat (3) begin @(negedge PCLK); #1; end
        check("mid_rst_quiet", 64'(rsp_valid), 64'(0));
        check("leftover_rsp", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
